inst_queue: RTL and testbench
=============================

# inst_queue

Dual-issue instruction queue between fetch and decode. Fetch writes up to two {pc, inst} pairs per cycle. Decode reads up to two per cycle as a master/slave pair. The pair's rs/rt fields go to register-file read and the forwarding muxes. The queue decouples I-cache latency from decode stalls and drops all contents on flush (branch redirect, exception).

## Interface
- DEPTH, 16, entry count; power of two, ≥4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all entries; higher priority than any read or write
- fetch_wen_0  in  1  write slot 0 valid
- fetch_pc_0 / fetch_inst_0  in  32/32  slot 0 payload
- fetch_wen_1  in  1  write slot 1 valid; honoured only with fetch_wen_0
- fetch_pc_1 / fetch_inst_1  in  32/32  slot 1 payload, younger than slot 0
- almost_full  out  1  count ≥ DEPTH-2; fetch must not write while set
- read_master  in  1  decode consumes head entry
- read_slave  in  1  decode consumes head+1; honoured only with read_master
- master_valid  out  1  count ≥ 1
- master_pc / master_inst  out  32/32  head entry, 0 when master_valid=0
- slave_valid  out  1  count ≥ 2
- slave_pc / slave_inst  out  32/32  head+1 entry, 0 when slave_valid=0
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer of DEPTH {pc, inst} entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
  - Storage is not reset.
- Outputs are show-ahead and combinational from registered state.
  - master = mem[rd_ptr]; slave = mem[rd_ptr+1 mod DEPTH].
  - pc/inst outputs are gated to 0 when the matching valid is low.
- Write, evaluated from pre-edge count:
  - wr_req = fetch_wen_0 + (fetch_wen_0 & fetch_wen_1).
  - Accepted writes = min(wr_req, DEPTH − count + rd_acc). Slot 0 is accepted first, then slot 1.
  - Excess entries are silently dropped. This is a protocol violation; almost_full prevents it.
- Read:
  - rd_req = read_master + (read_master & read_slave).
  - rd_acc = min(rd_req, count). Reading an empty or short queue consumes only existing entries.
- Update: count_next = count + wr_acc − rd_acc; pointers advance by their accepted amounts.
- A read and a write in the same cycle are legal.
  - A read frees space usable by the same-cycle write (full queue with 2 reads + 2 writes stays full).
  - No bypass: data written in cycle N is visible on the outputs from cycle N+1.
- Flush:
  - Next state is count=0 and rd_ptr=wr_ptr=0.
  - Same-cycle writes and reads are discarded.
  - Delay-slot retention is the redirecting stage's responsibility; the queue keeps nothing.
- Reset: same next state as flush. After reset: empty=1, all valids=0, all data outputs=0, almost_full=0, count=0.
- Reset and flush are both synchronous and do not depend on other inputs.

## Timing
- Write-to-visible latency: 1 cycle.
- Read-to-next-head latency: 0 cycles; outputs shift on the edge that consumes.
- almost_full, empty, count and the valids are functions of registered count only (no input-to-output combinational path).
- The data outputs and valids have no combinational path from fetch_* or read_* inputs.
- Flush or rst asserted in cycle N gives empty=1 in cycle N+1. Outputs in cycle N still show pre-flush contents.
- rst deasserted mid-stream: writes in the first post-reset cycle are accepted normally.

## Test plan
- Reset, then dual write {0xBFC00000,0x24080001},{0xBFC00004,0x24090002} → next cycle count=2, master_pc=0xBFC00000, slave_inst=0x24090002, slave_valid=1.
- Fill to 14 entries → almost_full=1 and count=14. Dual write plus dual read on a full 16-entry queue → count stays 16; order preserved across the wr_ptr wrap from 15 to 0.
- count=1, read_master=1 with read_slave=1 → count=0, empty=1, no underflow; next dual read leaves count=0.
- Write 3 entries; next cycle assert flush together with a dual write of pc 0x100/0x104 → next cycle count=0, master_valid=0, master_pc=0. The following write of pc 0x200 appears as master_pc=0x200.
- fetch_wen_1=1 with fetch_wen_0=0 → nothing written, count unchanged. read_slave=1 with read_master=0 → nothing consumed.
- Random 10k-cycle run: fetch respects almost_full, decode reads randomly, random flushes. Scoreboard checks pc order, valids and count every cycle.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch/decode-facing signal bundle of the dual-issue instruction queue.
// master = fetch/decode side driving requests, slave = the queue itself.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          fetch_wen_0;
  logic [31:0]   fetch_pc_0;
  logic [31:0]   fetch_inst_0;
  logic          fetch_wen_1;
  logic [31:0]   fetch_pc_1;
  logic [31:0]   fetch_inst_1;
  logic          almost_full;
  logic          read_master;
  logic          read_slave;
  logic          master_valid;
  logic [31:0]   master_pc;
  logic [31:0]   master_inst;
  logic          slave_valid;
  logic [31:0]   slave_pc;
  logic [31:0]   slave_inst;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output flush, fetch_wen_0, fetch_pc_0, fetch_inst_0,
    output fetch_wen_1, fetch_pc_1, fetch_inst_1, read_master, read_slave,
    input  almost_full, master_valid, master_pc, master_inst,
    input  slave_valid, slave_pc, slave_inst, empty, count
  );

  modport slave (
    input  flush, fetch_wen_0, fetch_pc_0, fetch_inst_0,
    input  fetch_wen_1, fetch_pc_1, fetch_inst_1, read_master, read_slave,
    output almost_full, master_valid, master_pc, master_inst,
    output slave_valid, slave_pc, slave_inst, empty, count
  );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: circular buffer taking up to two {pc, inst} pairs per cycle
// from fetch and presenting the two oldest to decode as show-ahead master/slave outputs.
module inst_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [1:0]    rd_req, rd_acc, wr_req, wr_acc;
  logic [CW:0]   space;
  logic          wr0_en, wr1_en;

  assign wr_ptr_p1 = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
  assign rd_ptr_p1 = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    rd_req = bus.read_master ? (bus.read_slave ? 2'd2 : 2'd1) : 2'd0;
    wr_req = bus.fetch_wen_0 ? (bus.fetch_wen_1 ? 2'd2 : 2'd1) : 2'd0;

    rd_acc = rd_req;
    if ({{(CW-2){1'b0}}, rd_req} > count_q) rd_acc = count_q[1:0];

    // Same-cycle reads free slots for same-cycle writes.
    space = (CW+1)'(DEPTH) - {1'b0, count_q} + {{(CW-1){1'b0}}, rd_acc};
    wr_acc = wr_req;
    if ({{(CW-1){1'b0}}, wr_req} > space) wr_acc = space[1:0];

    wr0_en   = (wr_acc != 2'd0) && !bus.flush;
    wr1_en   = (wr_acc == 2'd2) && !bus.flush;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);

    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset; valids gate everything read from it.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_mem_q[wr_ptr_q]   <= bus.fetch_pc_0;
      inst_mem_q[wr_ptr_q] <= bus.fetch_inst_0;
    end
    if (wr1_en) begin
      pc_mem_q[wr_ptr_p1]   <= bus.fetch_pc_1;
      inst_mem_q[wr_ptr_p1] <= bus.fetch_inst_1;
    end
  end

  always_comb begin
    bus.master_valid = (count_q != '0);
    bus.slave_valid  = (count_q >= CW'(2));
    bus.empty        = (count_q == '0);
    bus.almost_full  = (count_q >= CW'(DEPTH - 2));
    bus.count        = count_q;
    bus.master_pc    = '0;
    bus.master_inst  = '0;
    bus.slave_pc     = '0;
    bus.slave_inst   = '0;
    if (bus.master_valid) begin
      bus.master_pc   = pc_mem_q[rd_ptr_q];
      bus.master_inst = inst_mem_q[rd_ptr_q];
    end
    if (bus.slave_valid) begin
      bus.slave_pc   = pc_mem_q[rd_ptr_p1];
      bus.slave_inst = inst_mem_q[rd_ptr_p1];
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model, directed scenarios
// with literal expectations, then a long randomized run with flushes and resets.
module tb_inst_queue;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mq[$];
  int n_total = 0;
  int n_fail  = 0;
  logic [31:0] pc_seq = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of {pc, inst}; pop reads, then push writes while room remains.
  task automatic model_step(input bit r, input bit f, input bit w0, input bit w1,
                            input bit rm, input bit rs, input logic [63:0] e0,
                            input logic [63:0] e1);
    int nrd;
    if (r || f) begin
      mq.delete();
      return;
    end
    nrd = rm ? (rs ? 2 : 1) : 0;
    for (int i = 0; i < nrd; i++) if (mq.size() > 0) void'(mq.pop_front());
    if (w0 && mq.size() < DEPTH) mq.push_back(e0);
    if (w0 && w1 && mq.size() < DEPTH) mq.push_back(e1);
  endtask

  task automatic compare_all();
    int sz;
    sz = mq.size();
    chk("count",        32'(bus.count),        32'(sz));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= DEPTH - 2));
    chk("master_valid", 32'(bus.master_valid), 32'(sz >= 1));
    chk("slave_valid",  32'(bus.slave_valid),  32'(sz >= 2));
    chk("master_pc",    bus.master_pc,   sz >= 1 ? mq[0][63:32] : 32'h0);
    chk("master_inst",  bus.master_inst, sz >= 1 ? mq[0][31:0]  : 32'h0);
    chk("slave_pc",     bus.slave_pc,    sz >= 2 ? mq[1][63:32] : 32'h0);
    chk("slave_inst",   bus.slave_inst,  sz >= 2 ? mq[1][31:0]  : 32'h0);
  endtask

  // Drive one cycle of inputs, advance the model, then check just after the falling edge.
  task automatic cycle(input bit r, input bit f, input bit w0, input logic [31:0] p0,
                       input logic [31:0] i0, input bit w1, input logic [31:0] p1,
                       input logic [31:0] i1, input bit rm, input bit rs);
    rst              = r;
    bus.flush        = f;
    bus.fetch_wen_0  = w0;
    bus.fetch_pc_0   = p0;
    bus.fetch_inst_0 = i0;
    bus.fetch_wen_1  = w1;
    bus.fetch_pc_1   = p1;
    bus.fetch_inst_1 = i1;
    bus.read_master  = rm;
    bus.read_slave   = rs;
    model_step(r, f, w0, w1, rm, rs, {p0, i0}, {p1, i1});
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr2();
    cycle(0, 0, 1, pc_seq, ~pc_seq, 1, pc_seq + 4, ~(pc_seq + 4), 0, 0);
    pc_seq += 8;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit w0, w1, rm, rs, f, r;
    // Reset
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'hDEAD, 32'hBEEF, 1, 32'h1, 32'h2, 1, 1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_mpc",   bus.master_pc,  32'h0);
    chk("rst_af",    32'(bus.almost_full), 32'd0);

    // First dual write
    cycle(0, 0, 1, 32'hBFC00000, 32'h24080001, 1, 32'hBFC00004, 32'h24090002, 0, 0);
    chk("tp1_count", 32'(bus.count),       32'd2);
    chk("tp1_mpc",   bus.master_pc,        32'hBFC00000);
    chk("tp1_sinst", bus.slave_inst,       32'h24090002);
    chk("tp1_sval",  32'(bus.slave_valid), 32'd1);

    // Fill to 14, then to 16, then stream dual rd+wr across the pointer wrap
    for (int i = 0; i < 6; i++) wr2();
    chk("fill_af",    32'(bus.almost_full), 32'd1);
    chk("fill_count", 32'(bus.count),       32'd14);
    wr2();
    chk("full_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, pc_seq, ~pc_seq, 1, pc_seq + 4, ~(pc_seq + 4), 1, 1);
      pc_seq += 8;
    end
    chk("full_rw_count", 32'(bus.count), 32'd16);

    // Short-queue reads
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h50, 32'h51, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("under_count", 32'(bus.count), 32'd0);
    chk("under_empty", 32'(bus.empty), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("under2_count", 32'(bus.count), 32'd0);

    // Flush beats a same-cycle write
    wr2();
    cycle(0, 0, 1, 32'h60, 32'h61, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h100, 32'h1, 1, 32'h104, 32'h2, 1, 0);
    chk("flush_count", 32'(bus.count),        32'd0);
    chk("flush_mval",  32'(bus.master_valid), 32'd0);
    chk("flush_mpc",   bus.master_pc,         32'h0);
    cycle(0, 0, 1, 32'h200, 32'h3, 0, 0, 0, 0, 0);
    chk("post_flush_mpc", bus.master_pc, 32'h200);

    // Slot-1/slave requests without their slot-0/master partner are ignored
    cycle(0, 0, 0, 32'h300, 32'h4, 1, 32'h304, 32'h5, 0, 0);
    chk("wen1_only_count", 32'(bus.count), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rs_only_count", 32'(bus.count), 32'd1);
    chk("rs_only_mpc",   bus.master_pc,  32'h200);

    // Randomized run; fetch obeys the model's almost_full view
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(499) == 0);
      f  = ($urandom_range(63) == 0);
      w0 = (mq.size() < DEPTH - 2) && $urandom_range(3) != 0;
      w1 = $urandom_range(1) == 1;
      rm = $urandom_range(2) != 0;
      rs = $urandom_range(1) == 1;
      cycle(r, f, w0, pc_seq, $urandom, w1, pc_seq + 4, $urandom, rm, rs);
      pc_seq += 8;
    end
    idle();

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule
